// File: rtl/bsort_feeder_if.sv
// Stream-side bundle of the bubble-sort feeder: upstream pixel handshake and sorter drive lines.
interface bsort_feeder_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        sort_load;
    logic [23:0] sort_in;
    logic        sort_out_valid;
    logic        sort_clr;

    // Feeder side.
    modport master (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output sort_load,
        output sort_in,
        input  sort_out_valid,
        output sort_clr
    );

    // Environment side: upstream source plus the sorter.
    modport slave (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  sort_load,
        input  sort_in,
        output sort_out_valid,
        input  sort_clr
    );
endinterface

// File: rtl/bsort_feeder.sv
// Ping-pong frame buffer feeding 32-pixel frames to the bubble-sort engine.
// Filling of one bank overlaps with loading/sorting of the other.
module bsort_feeder (
    input  logic           clk,
    input  logic           reset,
    bsort_feeder_if.master bus,
    output logic [7:0]     frame_cnt,
    output logic           proto_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StClr} state_e;

    // Fill side
    logic        wr_bank_q, wr_bank_d;
    logic [4:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  bank_full_q, bank_full_d;
    logic        pix_fire;
    logic        fill_done;
    logic [23:0] mem_q [2][32];

    // Sort side
    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        rd_bank_q, rd_bank_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        proto_err_q, proto_err_d;
    logic        bank_clr;
    logic        sort_load_q, sort_load_d;
    logic [23:0] sort_in_q, sort_in_d;
    logic        sort_clr_q, sort_clr_d;

    assign bus.pix_ready = ~bank_full_q[wr_bank_q];
    assign pix_fire      = bus.pix_valid & bus.pix_ready;
    assign fill_done     = pix_fire & (wr_ptr_q == 5'd31);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        if (pix_fire) begin
            wr_ptr_d = wr_ptr_q + 5'd1;
            if (fill_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    // Set and clear always hit different banks, so applying both is safe.
    always_comb begin
        bank_full_d = bank_full_q;
        if (bank_clr) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (fill_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= 5'd0;
            bank_full_q <= 2'b00;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            bank_full_q <= bank_full_d;
        end
    end

    // Frame storage has no reset; contents are only read once a bank is marked full.
    always_ff @(posedge clk) begin
        if (pix_fire) begin
            mem_q[wr_bank_q][wr_ptr_q] <= bus.pix_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (bank_full_q[rd_bank_q]) state_d = StLoad;
            StLoad: if (cnt_q == 6'd31) state_d = StWait;
            StWait: if (bus.sort_out_valid && cnt_q == 6'd31) state_d = StClr;
            StClr:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;
        proto_err_d = proto_err_q;
        bank_clr    = 1'b0;
        sort_load_d = 1'b0;
        sort_in_d   = 24'd0;
        sort_clr_d  = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d       = 6'd0;
                proto_err_d = proto_err_q | bus.sort_out_valid;
            end
            StLoad: begin
                sort_load_d = 1'b1;
                sort_in_d   = mem_q[rd_bank_q][cnt_q[4:0]];
                cnt_d       = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
                proto_err_d = proto_err_q | bus.sort_out_valid;
            end
            StWait: begin
                if (bus.sort_out_valid) begin
                    cnt_d = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
                    // Registered clear lines up exactly with the CLR state cycle.
                    sort_clr_d = (cnt_q == 6'd31);
                end
            end
            StClr: begin
                bank_clr    = 1'b1;
                rd_bank_d   = ~rd_bank_q;
                frame_cnt_d = frame_cnt_q + 8'd1;
                proto_err_d = proto_err_q | bus.sort_out_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= 6'd0;
            rd_bank_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            proto_err_q <= 1'b0;
            sort_load_q <= 1'b0;
            sort_in_q   <= 24'd0;
            sort_clr_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rd_bank_q   <= rd_bank_d;
            frame_cnt_q <= frame_cnt_d;
            proto_err_q <= proto_err_d;
            sort_load_q <= sort_load_d;
            sort_in_q   <= sort_in_d;
            sort_clr_q  <= sort_clr_d;
        end
    end

    assign bus.sort_load = sort_load_q;
    assign bus.sort_in   = sort_in_q;
    assign bus.sort_clr  = sort_clr_q;
    assign frame_cnt     = frame_cnt_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_bsort_feeder.sv
// Bench for bsort_feeder: directed steps with random data/gaps, checked against a frame-level model.
module tb_bsort_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] frame_cnt;
    logic       proto_err;

    bsort_feeder_if bif ();

    bsort_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .frame_cnt (frame_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model, advanced once per clock edge.
    int          edge_n = 0;
    int          m_cnt = 0;       // pixels of the frame being filled
    int          held = 0;        // complete frames not yet released
    int          res = 0;         // results counted for the frame in flight
    int          start_edge = 0;  // edge of the first visible load of the frame in flight
    int          idle_edge = 0;   // edge at which the sort side last became idle
    int          clr_vis = -10;   // edge after which sort_clr is visible
    int          frames = 0;
    bit          in_flight = 1'b0;
    bit          perr = 1'b0;
    logic [23:0] pix_q[$];
    int          done_q[$];
    bit          exp_load;
    bit          exp_clr;
    logic [23:0] exp_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    function automatic void reset_model();
        pix_q.delete();
        done_q.delete();
        m_cnt     = 0;
        held      = 0;
        res       = 0;
        frames    = 0;
        in_flight = 1'b0;
        perr      = 1'b0;
        idle_edge = edge_n;
        clr_vis   = -10;
    endfunction

    // A result pulse sampled at the next edge is legal only after the whole frame is loaded.
    function automatic bit ov_legal();
        return in_flight && (edge_n + 1 >= start_edge + 32) && (res < 32);
    endfunction

    function automatic void model_edge(input bit acc, input logic [23:0] d, input bit ov);
        int c;
        if (acc) begin
            pix_q.push_back(d);
            m_cnt++;
            if (m_cnt == 32) begin
                m_cnt = 0;
                held++;
                done_q.push_back(edge_n);
            end
        end
        if (ov) begin
            if (in_flight && edge_n >= start_edge + 32 && res < 32) begin
                res++;
                if (res == 32) clr_vis = edge_n;
            end else begin
                perr = 1'b1;
            end
        end
        if (in_flight && res == 32 && edge_n == clr_vis + 1) begin
            held--;
            frames    = (frames + 1) % 256;
            idle_edge = edge_n;
            in_flight = 1'b0;
        end
        if (!in_flight && done_q.size() > 0) begin
            c          = done_q.pop_front();
            start_edge = ((c > idle_edge) ? c : idle_edge) + 2;
            in_flight  = 1'b1;
            res        = 0;
        end
        exp_load = in_flight && edge_n >= start_edge && edge_n <= start_edge + 31;
        exp_in   = (exp_load && pix_q.size() > 0) ? pix_q.pop_front() : 24'd0;
        exp_clr  = (edge_n == clr_vis);
    endfunction

    task automatic tick(input bit v, input logic [23:0] d, input bit ov, output bit acc);
        bit exp_rdy;
        bif.pix_valid      = v;
        bif.pix_data       = d;
        bif.sort_out_valid = ov;
        exp_rdy = (held < 2);
        chk("pix_ready", 32'(bif.pix_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(acc, d, ov);
        chk("sort_load", 32'(bif.sort_load), 32'(exp_load));
        chk("sort_in", 32'(bif.sort_in), 32'(exp_in));
        chk("sort_clr", 32'(bif.sort_clr), 32'(exp_clr));
        chk("frame_cnt", 32'(frame_cnt), 32'(frames));
        chk("proto_err", 32'(proto_err), 32'(perr));
    endtask

    // Offer n pixels (optionally counting down from 32), optionally answer with results
    // and optionally continue until every accepted frame is released.
    task automatic stream(input int n, input int gap_pct, input bit results, input bit drain,
                          input bit countdown);
        int          sent;
        int          cyc;
        logic [23:0] d;
        bit          v;
        bit          ov;
        bit          acc;
        sent = 0;
        cyc  = 0;
        d    = countdown ? 24'd32 : 24'($urandom);
        while (cyc < 5000 && !(sent >= n && (!drain || (!in_flight && held == 0)))) begin
            v  = (sent < n) && (int'($urandom_range(99)) >= gap_pct);
            ov = results && ov_legal();
            tick(v, d, ov, acc);
            if (acc) begin
                sent++;
                d = countdown ? 24'(32 - sent) : 24'($urandom);
            end
            cyc++;
        end
        chk("stream_bound", 32'(cyc < 5000), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_load"}, 32'(bif.sort_load), 32'd0);
        chk({tag, "_in"}, 32'(bif.sort_in), 32'd0);
        chk({tag, "_clr"}, 32'(bif.sort_clr), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_proto_err"}, 32'(proto_err), 32'd0);
        chk({tag, "_ready"}, 32'(bif.pix_ready), 32'd1);
    endtask

    initial begin
        bit acc;
        int cyc;
        bif.pix_valid      = 1'b0;
        bif.pix_data       = 24'd0;
        bif.sort_out_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        reset_model();

        // Descending frame back to back, then its 32 results.
        stream(32, 0, 1'b0, 1'b0, 1'b1);
        stream(0, 0, 1'b1, 1'b1, 1'b0);
        chk("frame1_cnt", 32'(frame_cnt), 32'd1);
        chk("frame1_perr", 32'(proto_err), 32'd0);

        // Fill both banks while results are withheld, stall, then release.
        stream(64, 0, 1'b0, 1'b0, 1'b0);
        chk("both_full_ready", 32'(bif.pix_ready), 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b1, 24'hABCDEF, 1'b0, acc);
        stream(32, 0, 1'b1, 1'b0, 1'b0);
        stream(0, 0, 1'b1, 1'b1, 1'b0);
        chk("after_96_cnt", 32'(frame_cnt), 32'd4);

        // Random upstream gaps.
        stream(64, 50, 1'b1, 1'b1, 1'b0);
        chk("gaps_cnt", 32'(frame_cnt), 32'd6);

        // Result pulse during the load burst is a protocol error and stays sticky.
        stream(32, 0, 1'b0, 1'b0, 1'b0);
        cyc = 0;
        while (edge_n + 1 != start_edge + 10 && cyc < 100) begin
            tick(1'b0, 24'd0, 1'b0, acc);
            cyc++;
        end
        chk("reach_load_bound", 32'(cyc < 100), 32'd1);
        tick(1'b0, 24'd0, 1'b1, acc);
        chk("perr_set", 32'(proto_err), 32'd1);
        stream(0, 0, 1'b1, 1'b1, 1'b0);
        stream(32, 30, 1'b1, 1'b1, 1'b0);
        chk("perr_sticky", 32'(proto_err), 32'd1);

        // Reset during WAIT after 10 results.
        stream(32, 0, 1'b0, 1'b0, 1'b0);
        cyc = 0;
        while (!(in_flight && res == 10) && cyc < 200) begin
            tick(1'b0, 24'd0, ov_legal(), acc);
            cyc++;
        end
        chk("reach_wait_bound", 32'(cyc < 200), 32'd1);
        bif.sort_out_valid = 1'b0;
        reset = 1'b1;
        #2;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        reset_model();
        stream(32, 20, 1'b1, 1'b1, 1'b0);
        chk("post_reset_cnt", 32'(frame_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
